fp_mul_pipe: RTL and testbench
==============================

# fp_mul_pipe

Parametrised, fully pipelined IEEE-754-style floating-point multiplier with a valid/ready stream interface, four rounding modes and exception flags. It accepts one operand pair per cycle at a fixed 4-cycle latency. It sits in the datapath's arithmetic cluster alongside the adder and rounding blocks and feeds vector dot-product accumulators.

## Interface
- EXP_W, 8, exponent field width (≥4).
- MAN_W, 23, stored fraction width (≥4); word width W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  pipeline can accept this cycle.
- a, b  in  W  operands {sign, exp, frac}.
- round_mode  in  2  00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf); sampled with operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  product.
- flags  out  4  {NV invalid, OF overflow, UF underflow, NX inexact}, qualified by out_valid.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Global advance = !out_valid || out_ready; in_ready = advance (combinational). On !advance all stages hold; no data lost or duplicated; bubbles are not squeezed.
- S1: unpack, classify (zero, sub, normal, inf, NaN), sign = sa^sb, raw exponent ea+eb-BIAS (EXP_W+2 bits signed, subnormals use exp 1), (MAN_W+1)x(MAN_W+1) mantissa multiply.
- S2: normalise. Product bit 2·MAN_W+1 set → shift right 1, exp+1; otherwise leading-zero count, shift left. Exp ≤ 0 → right shift by 1-exp into subnormal range, shifted-out bits OR into sticky; shift saturates at MAN_W+3.
- S3: round on guard/round/sticky per round_mode; mantissa carry-out increments exponent (subnormal → min normal allowed).
- S4: pack into output register; overflow, specials and flags applied.
- Specials: any NaN input → canonical qNaN {0, all-ones, 1, zeros}, NV only if an input is signalling NaN; 0×inf → qNaN, NV; inf×finite → signed inf; 0×finite → signed zero. No flags for exact specials.
- Overflow (rounded exp ≥ 2^EXP_W-1): RNE → ±inf; RTZ → ±max finite; RUP → +inf / −max finite; RDN → −inf / +max finite. OF and NX set.
- UF: result tiny before rounding, non-zero and inexact. NX: any discarded nonzero bit.

## Timing
- Latency exactly 4 advancing cycles: input accepted at edge N → out_valid high after edge N+4 if no stall.
- Throughput 1/cycle while out_ready high.
- out_valid held with result/flags stable until accepted.
- Reset: all stage valids 0, out_valid 0, result 0, flags 0; in_ready 1 one cycle after reset. Reset mid-operation discards all in-flight ops; no output produced for them.
- Simultaneous transfer in and out in the same cycle is legal and required at full rate.
- round_mode travels with its operands; changes do not affect in-flight ops.

## Configuration
- FP_MUL_DENORM_EN defined: subnormal inputs normalised, subnormal results produced and rounded as above.
- Undefined: subnormal inputs treated as signed zero (no flag); any result with rounded exp < 1 flushed to signed zero with UF and NX set; S2 right-shift logic removed. Latency unchanged.

## Test plan
- 0x3FC00000 × 0x40000000, RNE → 0x40400000, flags 0000, out_valid 4 cycles after accept.
- 0x3F800001 × 0x3F800001 → RNE/RTZ/RDN 0x3F800002, RUP 0x3F800003, NX only.
- 0x7F7FFFFF × 0x40000000 → RNE 0x7F800000, RTZ 0x7F7FFFFF, flags OF+NX; 0x00000000 × 0x7F800000 → 0x7FC00000, NV.
- 0x00800000 × 0x3F000000 → with FP_MUL_DENORM_EN 0x00400000 flags 0000; without 0x00000000, UF+NX.
- 8 back-to-back ops, out_ready low for cycles 5-7 → in_ready low exactly while stalled, 8 results in order, none lost or duplicated.
- rst asserted with 3 ops in flight → out_valid 0 and result 0 next cycle, no stale output afterwards; next op returns correct result at latency 4.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: fully pipelined floating-point multiplier, valid/ready stream, four rounding modes.
// Define FP_MUL_DENORM_EN for subnormal operands/results; otherwise subnormals flush to signed zero.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [1:0]           round_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int RW   = EXP_W + 2;
    localparam int XW   = EXP_W + $clog2(PW) + 3;
    localparam int GW   = MAN_W + 3;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {RM_RNE = 2'b00, RM_RTZ = 2'b01, RM_RUP = 2'b10, RM_RDN = 2'b11} rm_e;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_e;

    logic advance;
    logic v0_q, v1_q, v2_q, v3_q, v4_q;

    assign advance   = !v4_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = v4_q;

    // Operand capture register.
    logic [W-1:0] a0_q, b0_q;
    rm_e          rm0_q;

    // ---------------- S1: unpack, classify, multiply ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [MAN_W:0]   ma, mb;
    special_e         sp1_d, sp1_q;
    logic             nv1_d, nv1_q;
    logic             sign1_q;
    logic [RW-1:0]    exp1_d, exp1_q;
    logic [PW-1:0]    prod1_d, prod1_q;
    rm_e              rm1_q;

    assign {sa, ea, fa} = a0_q;
    assign {sb, eb, fb} = b0_q;
    assign a_inf = (ea == '1) && (fa == '0);
    assign b_inf = (eb == '1) && (fb == '0);
    assign a_nan = (ea == '1) && (fa != '0);
    assign b_nan = (eb == '1) && (fb != '0);
`ifdef FP_MUL_DENORM_EN
    assign a_zero = (ea == '0) && (fa == '0);
    assign b_zero = (eb == '0) && (fb == '0);
`else
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
`endif
    // Subnormals carry a zero hidden bit and the minimum exponent.
    assign ma      = {ea != '0, fa};
    assign mb      = {eb != '0, fb};
    assign ea_eff  = (ea == '0) ? EXP_W'(1) : ea;
    assign eb_eff  = (eb == '0) ? EXP_W'(1) : eb;
    assign exp1_d  = RW'(ea_eff) + RW'(eb_eff) - RW'(BIAS);
    assign prod1_d = PW'(ma) * PW'(mb);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sp1_d = SP_NONE;
        nv1_d = 1'b0;
        if (a_nan || b_nan) begin
            sp1_d = SP_NAN;
            nv1_d = (a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]);
        end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            sp1_d = SP_NAN;
            nv1_d = 1'b1;
        end else if (a_inf || b_inf) begin
            sp1_d = SP_INF;
        end else if (a_zero || b_zero) begin
            sp1_d = SP_ZERO;
        end
    end

    // ---------------- S2: normalise ----------------
    logic [XW-1:0] exp_ext, e1, exp2_d, exp2_q;
    logic [PW-1:0] norm;
    logic [GW-1:0] top, mant2_d, mant2_q;
    logic          sticky2_d, sticky2_q, sign2_q;
    special_e      sp2_q;
    logic          nv2_q;
    rm_e           rm2_q;
`ifdef FP_MUL_DENORM_EN
    localparam int LZW = $clog2(PW + 1);
    localparam int SHW = $clog2(GW + 1);
    logic [LZW-1:0] lz;
    logic           found, lost, tiny2_d, tiny2_q, tiny3_q;
    logic [XW-1:0]  diff;
    logic [SHW-1:0] sh;
`endif

    always_comb begin
        exp_ext = {{(XW - RW){exp1_q[RW-1]}}, exp1_q};
`ifdef FP_MUL_DENORM_EN
        lz    = '0;
        found = 1'b0;
        // NOTE: blocking assignments here build a combinational chain; state elsewhere uses <=.
        for (int i = PW - 1; i >= 0; i--) begin
            if (!found) begin
                if (prod1_q[i]) found = 1'b1;
                else            lz    = lz + LZW'(1);
            end
        end
        norm = prod1_q << lz;
        e1   = exp_ext + XW'(1) - XW'(lz);
`else
        norm = prod1_q[PW-1] ? prod1_q : (prod1_q << 1);
        e1   = prod1_q[PW-1] ? exp_ext + XW'(1) : exp_ext;
`endif
        top       = norm[PW-1 -: GW];
        mant2_d   = top;
        sticky2_d = |norm[PW-GW-1:0];
        exp2_d    = e1;
`ifdef FP_MUL_DENORM_EN
        tiny2_d = $signed(e1) < $signed(XW'(1));
        diff    = '0;
        sh      = '0;
        lost    = 1'b0;
        if (tiny2_d) begin
            diff = XW'(1) - e1;
            sh   = ($signed(diff) > $signed(XW'(GW))) ? SHW'(GW) : SHW'(diff);
            for (int i = 0; i < GW; i++) begin
                if (SHW'(i) < sh) lost = lost | top[i];
            end
            mant2_d   = top >> sh;
            sticky2_d = sticky2_d | lost;
            exp2_d    = XW'(1);
        end
`endif
    end

    // ---------------- S3: round ----------------
    logic [MAN_W:0]   mant_s3, mant3_d, mant3_q;
    logic [MAN_W+1:0] sum;
    logic             g, r, inc, nx3_d, nx3_q, sign3_q, nv3_q;
    logic [XW-1:0]    exp3_d, exp3_q;
    special_e         sp3_q;
    rm_e              rm3_q;

    always_comb begin
        mant_s3 = mant2_q[GW-1:2];
        g       = mant2_q[1];
        r       = mant2_q[0];
        nx3_d   = g || r || sticky2_q;
        inc     = 1'b0;
        case (rm2_q)
            RM_RNE: inc = g && (r || sticky2_q || mant_s3[0]);
            RM_RTZ: inc = 1'b0;
            RM_RUP: inc = !sign2_q && nx3_d;
            RM_RDN: inc = sign2_q && nx3_d;
        endcase
        sum = {1'b0, mant_s3} + (MAN_W + 2)'(inc);
        if (sum[MAN_W+1]) begin
            mant3_d = sum[MAN_W+1:1];
            exp3_d  = exp2_q + XW'(1);
        end else begin
            mant3_d = sum[MAN_W:0];
            exp3_d  = exp2_q;
        end
    end

    // ---------------- S4: pack, overflow, specials ----------------
    logic [W-1:0]     result_d, result_q, inf_w, max_w;
    logic [3:0]       flags_d, flags_q;
    logic [EXP_W-1:0] exp_field;
    logic             uf;

    always_comb begin
        exp_field = mant3_q[MAN_W] ? exp3_q[EXP_W-1:0] : '0;
        inf_w     = {sign3_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        max_w     = {sign3_q, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`ifdef FP_MUL_DENORM_EN
        uf = tiny3_q && nx3_q;
`else
        uf = 1'b0;
`endif
        result_d = {sign3_q, exp_field, mant3_q[MAN_W-1:0]};
        flags_d  = {1'b0, 1'b0, uf, nx3_q};
        if ($signed(exp3_q) >= $signed(XW'(EMAX))) begin
            flags_d = 4'b0101;
            case (rm3_q)
                RM_RNE: result_d = inf_w;
                RM_RTZ: result_d = max_w;
                RM_RUP: result_d = sign3_q ? max_w : inf_w;
                RM_RDN: result_d = sign3_q ? inf_w : max_w;
            endcase
        end
`ifndef FP_MUL_DENORM_EN
        else if ($signed(exp3_q) < $signed(XW'(1))) begin
            result_d = {sign3_q, {(W - 1){1'b0}}};
            flags_d  = 4'b0011;
        end
`endif
        case (sp3_q)
            SP_NAN: begin
                result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
                flags_d  = {nv3_q, 3'b000};
            end
            SP_INF: begin
                result_d = inf_w;
                flags_d  = 4'b0000;
            end
            SP_ZERO: begin
                result_d = {sign3_q, {(W - 1){1'b0}}};
                flags_d  = 4'b0000;
            end
            default: ;
        endcase
    end

    // ---------------- Control registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            v4_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (advance) begin
            v0_q <= in_valid;
            v1_q <= v0_q;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            if (v3_q) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    // NOTE: datapath stage registers are not reset; the stage valids qualify them.
    always_ff @(posedge clk) begin
        if (advance) begin
            a0_q      <= a;
            b0_q      <= b;
            rm0_q     <= rm_e'(round_mode);
            sign1_q   <= sa ^ sb;
            exp1_q    <= exp1_d;
            prod1_q   <= prod1_d;
            sp1_q     <= sp1_d;
            nv1_q     <= nv1_d;
            rm1_q     <= rm0_q;
            sign2_q   <= sign1_q;
            exp2_q    <= exp2_d;
            mant2_q   <= mant2_d;
            sticky2_q <= sticky2_d;
            sp2_q     <= sp1_q;
            nv2_q     <= nv1_q;
            rm2_q     <= rm1_q;
            sign3_q   <= sign2_q;
            exp3_q    <= exp3_d;
            mant3_q   <= mant3_d;
            nx3_q     <= nx3_d;
            sp3_q     <= sp2_q;
            nv3_q     <= nv2_q;
            rm3_q     <= rm2_q;
`ifdef FP_MUL_DENORM_EN
            tiny2_q   <= tiny2_d;
            tiny3_q   <= tiny2_q;
`endif
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed self-checking bench for fp_mul_pipe (binary32 configuration).
// Honours FP_MUL_DENORM_EN for the subnormal-result vector.
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [1:0]  round_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .round_mode (round_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated operation: presents it, scrambles round_mode after acceptance, measures latency.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [1:0] rm, input logic [31:0] exp_res, input logic [3:0] exp_flags);
        int lat;
        @(negedge clk);
        a = op_a;
        b = op_b;
        round_mode = rm;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        round_mode = ~rm;
        a = 32'h0;
        b = 32'h0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " result"}, 64'(result), 64'(exp_res));
        check({tag, " flags"}, 64'(flags), 64'(exp_flags));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        int received;
        int stale;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 32'h0;
        b = 32'h0;
        round_mode = 2'b00;
        repeat (3) @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset flags", 64'(flags), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 64'(in_ready), 64'd1);

        run_op("1.5x2 rne", 32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000);

        run_op("ulp rne", 32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 4'b0001);
        run_op("ulp rtz", 32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 4'b0001);
        run_op("ulp rup", 32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 4'b0001);
        run_op("ulp rdn", 32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800002, 4'b0001);

        run_op("ovf rne", 32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000, 4'b0101);
        run_op("ovf rtz", 32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F7FFFFF, 4'b0101);
        run_op("ovf neg rup", 32'hFF7FFFFF, 32'h40000000, 2'b10, 32'hFF7FFFFF, 4'b0101);
        run_op("ovf neg rdn", 32'hFF7FFFFF, 32'h40000000, 2'b11, 32'hFF800000, 4'b0101);

        run_op("0 x inf", 32'h00000000, 32'h7F800000, 2'b00, 32'h7FC00000, 4'b1000);
        run_op("snan", 32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b1000);
        run_op("qnan", 32'h7FC00001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b0000);
        run_op("inf x -2", 32'h7F800000, 32'hC0000000, 2'b00, 32'hFF800000, 4'b0000);
        run_op("0 x -2", 32'h00000000, 32'hC0000000, 2'b00, 32'h80000000, 4'b0000);

`ifdef FP_MUL_DENORM_EN
        run_op("tiny", 32'h00800000, 32'h3F000000, 2'b00, 32'h00400000, 4'b0000);
`else
        run_op("tiny", 32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, 4'b0011);
`endif

        // Eight back-to-back ops (x * 2.0) with the consumer stalling on cycles 5..7.
        issued = 0;
        received = 0;
        for (int cyc = 0; cyc < 40 && received < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid = (issued < 8);
            a = 32'h3F800000 + 32'(issued) * 32'h00100000;
            b = 32'h40000000;
            round_mode = 2'b00;
            #1;
            check($sformatf("stream in_ready c%0d", cyc), 64'(in_ready), 64'(!(cyc >= 5 && cyc <= 7)));
            if (out_valid && out_ready) begin
                check($sformatf("stream result %0d", received), 64'(result),
                      64'(32'h3F800000 + 32'(received) * 32'h00100000 + 32'h00800000));
                check($sformatf("stream flags %0d", received), 64'(flags), 64'd0);
                received++;
            end
            if (in_valid && in_ready) issued++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream count", 64'(received), 64'd8);
        repeat (6) @(negedge clk);
        check("stream drained", 64'(out_valid), 64'd0);

        // Reset with three ops in flight.
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h3FC00000;
        b = 32'h40000000;
        round_mode = 2'b00;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid reset out_valid", 64'(out_valid), 64'd0);
        check("mid reset result", 64'(result), 64'd0);
        check("mid reset flags", 64'(flags), 64'd0);
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no stale output", 64'(stale), 64'd0);
        run_op("after reset", 32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
